// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80-style bench bus masters: bus states, T-state count and response record.
package z80_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StT1,
    StT2,
    StTw,
    StT3
  } bus_state_e;

  localparam int unsigned TStates = 3;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       err;
  } rsp_t;

endpackage

// File: rtl/z80_mem_reader_if.sv
// Request/response handshake plus CE/OE memory bus between the read master and the bench.
interface z80_mem_reader_if #(
  parameter int unsigned ADDR_W = 15
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_len;
  logic              rsp_valid;
  logic [7:0]        rsp_data;
  logic              rsp_last;
  logic              rsp_err;
  logic [ADDR_W-1:0] A;
  logic              CE_n;
  logic              OE_n;
  logic [7:0]        D;
  logic              WAIT_n;

  modport master (
    input  req_valid, req_addr, req_len, D, WAIT_n,
    output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err, A, CE_n, OE_n
  );

  modport slave (
    output req_valid, req_addr, req_len, D, WAIT_n,
    input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err, A, CE_n, OE_n
  );
endinterface

// File: rtl/z80_wait_timer.sv
// Counts consecutive wait-state cycles; flags the cycle that is the TIMEOUT-th wait state.
module z80_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic in_tw,
  output logic expired
);

  logic [7:0] cnt_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (in_tw) begin
      cnt_q <= cnt_q + 8'd1;
    end else begin
      cnt_q <= '0;
    end
  end

  // cnt_q holds the number of wait states already completed before this one.
  assign expired = in_tw && (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/z80_mem_reader.sv
// Z80-style memory read master: T1/T2/[TW]/T3 cycles per byte, bursts up to 16 bytes.
module z80_mem_reader
  import z80_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                CLK,
  input logic                RESET,
  z80_mem_reader_if.master   bus
);

  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  bus_state_e        state_q;
  logic [ADDR_W-1:0] a_q;
  logic [3:0]        remain_q;
  logic              ce_n_q;
  logic              oe_n_q;
  logic              ready_q;
  logic              rsp_valid_q;
  rsp_t              rsp_q;
  logic              tw_expired;

  z80_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .CLK    (CLK),
    .RESET  (RESET),
    .in_tw  (state_q == StTw),
    .expired(tw_expired)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      a_q         <= '0;
      remain_q    <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            state_q  <= StT1;
            a_q      <= bus.req_addr;
            remain_q <= bus.req_len;
            ce_n_q   <= 1'b0;
            oe_n_q   <= 1'b1;
            ready_q  <= 1'b0;
          end
        end
        StT1: begin
          state_q <= StT2;
          oe_n_q  <= 1'b0;
        end
        StT2: begin
          state_q <= bus.WAIT_n ? StT3 : StTw;
        end
        StTw: begin
          if (bus.WAIT_n) begin
            state_q <= StT3;
          end else if (tw_expired) begin
            // Abort drops any remaining bytes and releases the bus immediately.
            state_q     <= StIdle;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_q.data  <= 8'h00;
            rsp_q.last  <= 1'b1;
            rsp_q.err   <= 1'b1;
          end
        end
        StT3: begin
          rsp_valid_q <= 1'b1;
          rsp_q.data  <= bus.D;
          rsp_q.last  <= (remain_q == 4'd0);
          rsp_q.err   <= 1'b0;
          if (remain_q != 4'd0) begin
            remain_q <= remain_q - 4'd1;
            a_q      <= a_q + AddrOne;
            state_q  <= StT1;
            oe_n_q   <= 1'b1;
          end else begin
            state_q <= StIdle;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.A         = a_q;
  assign bus.CE_n      = ce_n_q;
  assign bus.OE_n      = oe_n_q;
  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_q.data;
  assign bus.rsp_last  = rsp_q.last;
  assign bus.rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_z80_mem_reader.sv
// Bench for z80_mem_reader: transaction-level timeline model plus directed and random requests.
module tb_z80_mem_reader;
  import z80_bus_pkg::*;

  localparam int unsigned ADDR_W  = 15;
  localparam int unsigned TIMEOUT = 4;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  z80_mem_reader_if #(.ADDR_W(ADDR_W)) bus ();

  z80_mem_reader #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  logic [7:0] rom [0:(1<<ADDR_W)-1];
  assign bus.D = (!bus.CE_n && !bus.OE_n) ? rom[bus.A] : 8'hFF;

  // One expected bus cycle; wait_n is what the device drives during that cycle.
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic              ce_n;
    logic              oe_n;
    logic              ready;
    logic              rv;
    logic [7:0]        data;
    logic              last;
    logic              err;
    logic              wait_n;
  } cyc_t;

  cyc_t              exp_q[$];
  logic [ADDR_W-1:0] last_a;
  int                wv[16];
  int                checks = 0;
  int                failures = 0;
  int                cyc = 0;
  int                acc_cyc = 0;
  int                rsp_n = 0;
  int                rsp_off = 0;
  logic [7:0]        rsp_d;
  logic              rsp_l;
  logic              rsp_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Expand a request into its per-cycle bus timeline from the wait-state count of each byte.
  task automatic build(input logic [ADDR_W-1:0] addr, input int len);
    cyc_t              r;
    logic [ADDR_W-1:0] a = addr;
    logic              p_v = 1'b0;
    logic [7:0]        p_d = 8'h00;
    logic              p_l = 1'b0;
    logic              p_e = 1'b0;
    for (int k = 0; k <= len; k++) begin
      r = '{a: a, ce_n: 1'b0, oe_n: 1'b1, ready: 1'b0, rv: p_v, data: p_d, last: p_l,
            err: p_e, wait_n: 1'($urandom_range(0, 1))};
      exp_q.push_back(r);
      r.rv = 1'b0;
      r.oe_n = 1'b0;
      r.wait_n = (wv[k] == 0);
      exp_q.push_back(r);
      for (int i = 0; i < wv[k] && i < int'(TIMEOUT); i++) begin
        r.wait_n = (i >= wv[k] - 1);
        exp_q.push_back(r);
      end
      if (wv[k] > int'(TIMEOUT)) begin
        p_v = 1'b1; p_d = 8'h00; p_l = 1'b1; p_e = 1'b1;
        break;
      end
      r.wait_n = 1'($urandom_range(0, 1));
      exp_q.push_back(r);
      p_v = 1'b1; p_d = rom[a]; p_l = (k == len); p_e = 1'b0;
      if (k < len) a = a + ADDR_W'(1);
    end
    r = '{a: a, ce_n: 1'b1, oe_n: 1'b1, ready: 1'b1, rv: p_v, data: p_d, last: p_l,
          err: p_e, wait_n: 1'($urandom_range(0, 1))};
    exp_q.push_back(r);
    last_a = a;
  endtask

  task automatic step(input logic rv_in, input logic [ADDR_W-1:0] addr, input logic [3:0] len);
    cyc_t cur;
    @(negedge CLK);
    cyc++;
    if (exp_q.size() > 0) cur = exp_q.pop_front();
    else cur = '{a: last_a, ce_n: 1'b1, oe_n: 1'b1, ready: 1'b1, rv: 1'b0, data: 8'h00,
                 last: 1'b0, err: 1'b0, wait_n: 1'($urandom_range(0, 1))};
    chk("A", 32'(bus.A), 32'(cur.a));
    chk("CE_n", 32'(bus.CE_n), 32'(cur.ce_n));
    chk("OE_n", 32'(bus.OE_n), 32'(cur.oe_n));
    chk("req_ready", 32'(bus.req_ready), 32'(cur.ready));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(cur.rv));
    if (cur.rv) begin
      chk("rsp_data", 32'(bus.rsp_data), 32'(cur.data));
      chk("rsp_last", 32'(bus.rsp_last), 32'(cur.last));
      chk("rsp_err", 32'(bus.rsp_err), 32'(cur.err));
    end
    if (bus.rsp_valid) begin
      rsp_n++;
      rsp_off = cyc - acc_cyc;
      rsp_d = bus.rsp_data;
      rsp_l = bus.rsp_last;
      rsp_e = bus.rsp_err;
    end
    bus.WAIT_n    = cur.wait_n;
    bus.req_valid = rv_in;
    bus.req_addr  = addr;
    bus.req_len   = len;
    if (rv_in && cur.ready) begin
      build(addr, int'(len));
      acc_cyc = cyc;
      rsp_n = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 4'd0);
  endtask

  task automatic clear_waits();
    for (int i = 0; i < 16; i++) wv[i] = 0;
  endtask

  initial begin
    int guard;
    RESET = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.req_len = '0;
    bus.WAIT_n = 1'b1;
    last_a = '0;
    clear_waits();
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 8'($urandom);
    rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'hA5;
    rom[4] = 8'h55; rom[5] = 8'h66; rom[6] = 8'h77; rom[7] = 8'h88; rom[8] = 8'h00;

    repeat (2) @(negedge CLK);
    chk("reset_A", 32'(bus.A), 32'h0);
    chk("reset_CE_n", 32'(bus.CE_n), 32'h1);
    chk("reset_ready", 32'(bus.req_ready), 32'h1);
    chk("reset_rsp_data", 32'(bus.rsp_data), 32'h0);
    RESET = 1'b0;
    idle(2);

    // Single read of ROM[3].
    step(1'b1, ADDR_W'(3), 4'd0);
    idle(1); chk("single_t1_ce", 32'(bus.CE_n), 32'h0); chk("single_t1_oe", 32'(bus.OE_n), 32'h1);
    idle(1); chk("single_t2_oe", 32'(bus.OE_n), 32'h0);
    idle(2);
    chk("single_rv", 32'(bus.rsp_valid), 32'h1);
    chk("single_data", 32'(bus.rsp_data), 32'hA5);
    chk("single_last", 32'(bus.rsp_last), 32'h1);
    idle(2);

    // Nine-byte burst from 0.
    step(1'b1, ADDR_W'(0), 4'd8);
    idle(1); chk("burst_first_A", 32'(bus.A), 32'h0);
    idle(3); chk("burst_first_data", 32'(rsp_d), 32'h11);
    idle(26);
    chk("burst_count", 32'(rsp_n), 32'd9);
    chk("burst_last_off", 32'(rsp_off), 32'd28);
    chk("burst_last_data", 32'(rsp_d), 32'h00);
    chk("burst_last_flag", 32'(rsp_l), 32'h1);

    // Two wait states.
    wv[0] = 2;
    step(1'b1, ADDR_W'(3), 4'd0);
    idle(8);
    chk("wait_off", 32'(rsp_off), 32'd6);
    chk("wait_data", 32'(rsp_d), 32'hA5);

    // Exactly TIMEOUT wait states still completes.
    wv[0] = int'(TIMEOUT);
    step(1'b1, ADDR_W'(3), 4'd0);
    idle(10);
    chk("tmo_edge_off", 32'(rsp_off), 32'd8);
    chk("tmo_edge_err", 32'(rsp_e), 32'h0);

    // Timeout abort.
    wv[0] = 20;
    step(1'b1, ADDR_W'(3), 4'd2);
    idle(7);
    chk("abort_rv", 32'(bus.rsp_valid), 32'h1);
    chk("abort_err", 32'(bus.rsp_err), 32'h1);
    chk("abort_data", 32'(bus.rsp_data), 32'h0);
    chk("abort_last", 32'(bus.rsp_last), 32'h1);
    idle(1);
    chk("abort_ce", 32'(bus.CE_n), 32'h1);
    chk("abort_ready", 32'(bus.req_ready), 32'h1);
    chk("abort_count", 32'(rsp_n), 32'd1);
    clear_waits();

    // Address wrap, with a request pulse while busy.
    step(1'b1, ADDR_W'(15'h7FFF), 4'd1);
    idle(1); chk("wrap_A0", 32'(bus.A), 32'h7FFF);
    step(1'b1, ADDR_W'(15'h1234), 4'd3);
    chk("busy_ready", 32'(bus.req_ready), 32'h0);
    idle(2); chk("wrap_A1", 32'(bus.A), 32'h0);
    idle(4);
    chk("wrap_count", 32'(rsp_n), 32'd2);

    // Asynchronous reset in a wait state of the second byte.
    wv[1] = 3;
    step(1'b1, ADDR_W'(15'h0100), 4'd3);
    idle(6);
    chk("rst_pre_oe", 32'(bus.OE_n), 32'h0);
    RESET = 1'b1;
    #1;
    chk("rst_ce", 32'(bus.CE_n), 32'h1);
    chk("rst_oe", 32'(bus.OE_n), 32'h1);
    chk("rst_rv", 32'(bus.rsp_valid), 32'h0);
    chk("rst_ready", 32'(bus.req_ready), 32'h1);
    exp_q.delete();
    last_a = '0;
    clear_waits();
    idle(1);
    RESET = 1'b0;
    idle(1);
    step(1'b1, ADDR_W'(3), 4'd0);
    idle(5);
    chk("post_rst_off", 32'(rsp_off), 32'd4);
    chk("post_rst_data", 32'(rsp_d), 32'hA5);

    // Randomized requests with random wait states, timeouts and busy pulses.
    for (int n = 0; n < 200; n++) begin
      idle($urandom_range(0, 3));
      for (int k = 0; k < 16; k++)
        wv[k] = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 2) : $urandom_range(3, 6);
      step(1'b1, ADDR_W'($urandom), 4'($urandom_range(0, 15)));
      guard = 0;
      while (exp_q.size() > 0 && guard < 3000) begin
        step(1'($urandom_range(0, 7) == 0), ADDR_W'($urandom), 4'($urandom_range(0, 15)));
        guard++;
      end
      if (guard >= 3000) begin
        failures++;
        $display("FAIL drain cycle=%0d actual=%0d required=<3000", cyc, guard);
      end
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
